rv32f_csr_unit: RTL and testbench
=================================

Name: rv32f_csr_unit

Overview:
- Parametrised floating-point CSR unit holding fflags, frm and the fcsr view.
- Serves CSRRW/CSRRS/CSRRC-style requests from the execute stage over a valid/ready handshake, with a registered response.
- Accumulates sticky exception flags from FLAG_LANES parallel FP write-back lanes.
- Resolves dynamic rounding mode for decode.

Parameters:
FLAG_LANES, 2, number of FP pipelines reporting exception flags each cycle (1..8)
ID_WIDTH, 4, width of request tag echoed on the response

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  CSR request valid
req_ready  output  1  request accepted when req_valid && req_ready
req_addr  input  12  CSR address
req_op  input  2  00 read, 01 write, 10 set, 11 clear
req_wdata  input  32  write/set/clear operand
req_id  input  ID_WIDTH  request tag
resp_valid  output  1  response valid
resp_ready  input  1  response consumed
resp_rdata  output  32  CSR value before the operation
resp_illegal  output  1  unsupported address
resp_id  output  ID_WIDTH  echoed tag
flag_valid  input  FLAG_LANES  lane i reports flags this cycle
flag_bits  input  5*FLAG_LANES  lane i flags at [5i+4:5i], order NV DZ OF UF NX (bit4..bit0)
instr_rm  input  3  rm field of the instruction in decode
rm_resolved  output  3  effective rounding mode
rm_illegal  output  1  effective rm is reserved
frm_out  output  3  current frm

Behaviour:
- Reset (async, rst_n low): fflags=0, frm=0, resp_valid=0, resp_rdata=0, resp_illegal=0, resp_id=0. req_ready is 1 after reset.
- Addresses:
  - 0x001 fflags: rdata={27'b0,fflags}.
  - 0x002 frm: rdata={29'b0,frm}.
  - 0x003 fcsr: rdata={24'b0,frm,fflags}.
  - Any other address: resp_illegal=1, rdata=0, no state change.
- Write operand: only low 5/3/8 bits used for fflags/frm/fcsr; upper bits ignored.
- Operation on old value V: write → W; set → V|W; clear → V&~W. Read (op 00) changes nothing.
- Handshake:
  - One-entry response register. req_ready = !resp_valid || resp_ready (combinational).
  - Accept at edge → resp_valid=1 on the following cycle (latency 1). Response fields hold stable while resp_valid && !resp_ready.
  - Back-to-back accepts give full throughput.
- Flag accumulation: every cycle, F = OR over lanes i with flag_valid[i] of flag_bits lane i.
- Same-cycle ordering: lane flags are older than a concurrently accepted CSR op.
  - V = fflags | F is used for both rdata and the operation.
  - Result R is stored.
  - Example: lane NX + accepted fflags write 0 → rdata bit0=1, fflags=0.
- No accept: fflags <= fflags | F. frm changes only by CSR op.
- frm stores all 3 bits, including reserved values 5, 6, 7.
- rm_resolved (combinational) = (instr_rm==3'b111) ? frm : instr_rm.
- rm_illegal = rm_resolved in {5,6,7}. This includes instr_rm=5/6 and dynamic with frm in 5..7.
- Reset mid-transaction: pending response dropped; resp_valid=0 immediately (async).
- Flags arriving while response stalled still accumulate; the stalled rdata is not updated.

Optional Feature:
RV32F_CSR_EXC_COUNT_EN:
- Defined: adds a 32-bit counter at custom CSR 0x800.
- Each cycle it adds the number of lanes with flag_valid[i] && flag_bits lane i != 0, saturating at 0xFFFF_FFFF.
- Read returns the count. Write/set/clear apply normally; in the same cycle the CSR op takes precedence over the increment.
- Reset value 0.
- Not defined: 0x800 is illegal like any other unsupported address; no counter logic.

Test Plan:
- Reset, then read 0x003 → resp one cycle later, rdata=0x00, illegal=0, resp_id echoed.
- Write fcsr 0xFFFF_FFE5 → fcsr=0xE5: frm=7, fflags=0x05. Then instr_rm=7 → rm_resolved=7, rm_illegal=1. Then instr_rm=1 → rm_resolved=1, rm_illegal=0.
- Lane0 NX (0x01) and lane1 DZ (0x08) in same cycle, no request → next read 0x001 returns 0x09. Clear with W=0x08 → rdata 0x09, then fflags=0x01.
- Lane0 NV (0x10) in the cycle a set of fflags W=0x02 is accepted → rdata=0x10, fflags=0x12.
- Hold resp_ready=0 for 3 cycles with req_valid high → req_ready=0, resp stable, second request accepted the cycle resp_ready rises. Read 0x7C0 → resp_illegal=1, rdata=0.
- With RV32F_CSR_EXC_COUNT_EN: 4 cycles of both lanes reporting nonzero flags → read 0x800 returns 8. Without the macro: read 0x800 → resp_illegal=1.

Source files
------------

// File: rtl/rv32f_csr_unit.sv
// Floating-point CSR unit: fflags/frm/fcsr with sticky flag accumulation and dynamic-rm resolution.
// Latency: one cycle from request accept to registered response; rm_resolved/rm_illegal are combinational.
// Backpressure: one-entry response register, req_ready = !resp_valid || resp_ready. Optional: RV32F_CSR_EXC_COUNT_EN.
module rv32f_csr_unit #(
    parameter int FLAG_LANES = 2,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [11:0]             req_addr,
    input  logic [1:0]              req_op,
    input  logic [31:0]             req_wdata,
    input  logic [ID_WIDTH-1:0]     req_id,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic                    resp_illegal,
    output logic [ID_WIDTH-1:0]     resp_id,
    input  logic [FLAG_LANES-1:0]   flag_valid,
    input  logic [5*FLAG_LANES-1:0] flag_bits,
    input  logic [2:0]              instr_rm,
    output logic [2:0]              rm_resolved,
    output logic                    rm_illegal,
    output logic [2:0]              frm_out
);

    localparam logic [11:0] ADDR_FFLAGS = 12'h001;
    localparam logic [11:0] ADDR_FRM    = 12'h002;
    localparam logic [11:0] ADDR_FCSR   = 12'h003;
    localparam logic [1:0]  OP_READ     = 2'b00;
    localparam logic [1:0]  OP_WRITE    = 2'b01;
    localparam logic [1:0]  OP_SET      = 2'b10;

    logic [4:0]  fflags;
    logic [2:0]  frm;
    logic [4:0]  lane_or;
    logic [4:0]  fflags_cur;
    logic        accept;
    logic        legal;
    logic [31:0] old_val;
    logic [31:0] res;
    logic        wr_en;

    assign req_ready = !resp_valid || resp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        lane_or = '0;
        for (int i = 0; i < FLAG_LANES; i++) begin
            if (flag_valid[i]) begin
                lane_or = lane_or | flag_bits[5*i +: 5];
            end
        end
    end

    // Lane flags land before a same-cycle CSR op, so the op sees them in its old value.
    assign fflags_cur = fflags | lane_or;

`ifdef RV32F_CSR_EXC_COUNT_EN
    localparam logic [11:0] ADDR_EXCCNT = 12'h800;

    logic [31:0] exc_cnt;
    logic [3:0]  lane_cnt;
    logic [32:0] cnt_sum;
    logic [31:0] cnt_next;

    always_comb begin
        lane_cnt = '0;
        for (int i = 0; i < FLAG_LANES; i++) begin
            if (flag_valid[i] && (|flag_bits[5*i +: 5])) begin
                lane_cnt = lane_cnt + 4'd1;
            end
        end
    end

    assign cnt_sum  = {1'b0, exc_cnt} + {29'b0, lane_cnt};
    assign cnt_next = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
`endif

    always_comb begin
        old_val = '0;
        legal   = 1'b0;
        case (req_addr)
            ADDR_FFLAGS: begin
                old_val = {27'b0, fflags_cur};
                legal   = 1'b1;
            end
            ADDR_FRM: begin
                old_val = {29'b0, frm};
                legal   = 1'b1;
            end
            ADDR_FCSR: begin
                old_val = {24'b0, frm, fflags_cur};
                legal   = 1'b1;
            end
`ifdef RV32F_CSR_EXC_COUNT_EN
            ADDR_EXCCNT: begin
                old_val = exc_cnt;
                legal   = 1'b1;
            end
`endif
            default: begin
                old_val = '0;
                legal   = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (req_op)
            OP_READ:  res = old_val;
            OP_WRITE: res = req_wdata;
            OP_SET:   res = old_val | req_wdata;
            default:  res = old_val & ~req_wdata;
        endcase
    end

    assign wr_en = accept && legal && (req_op != OP_READ);

`ifndef RV32F_CSR_EXC_COUNT_EN
    logic unused_res_hi;
    assign unused_res_hi = ^res[31:8];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags <= '0;
            frm    <= '0;
        end else begin
            if (wr_en && (req_addr == ADDR_FFLAGS || req_addr == ADDR_FCSR)) begin
                fflags <= res[4:0];
            end else begin
                fflags <= fflags_cur;
            end
            if (wr_en && req_addr == ADDR_FRM) begin
                frm <= res[2:0];
            end else if (wr_en && req_addr == ADDR_FCSR) begin
                frm <= res[7:5];
            end
        end
    end

`ifdef RV32F_CSR_EXC_COUNT_EN
    // A CSR write to the counter wins over that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_cnt <= '0;
        end else if (wr_en && req_addr == ADDR_EXCCNT) begin
            exc_cnt <= res;
        end else begin
            exc_cnt <= cnt_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b0;
            resp_id      <= '0;
        end else if (accept) begin
            resp_valid   <= 1'b1;
            resp_rdata   <= old_val;
            resp_illegal <= !legal;
            resp_id      <= req_id;
        end else if (resp_ready) begin
            resp_valid   <= 1'b0;
        end
    end

    assign frm_out     = frm;
    assign rm_resolved = (instr_rm == 3'b111) ? frm : instr_rm;
    assign rm_illegal  = (rm_resolved == 3'd5) || (rm_resolved == 3'd6) || (rm_resolved == 3'd7);

endmodule

// File: tb/tb_rv32f_csr_unit.sv
// Scoreboard bench for rv32f_csr_unit: reference model pushes expected responses, monitor pops and compares.
module tb_rv32f_csr_unit;

    localparam int FL = 2;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [11:0]   req_addr;
    logic [1:0]    req_op;
    logic [31:0]   req_wdata;
    logic [IW-1:0] req_id;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic          resp_illegal;
    logic [IW-1:0] resp_id;
    logic [FL-1:0] flag_valid;
    logic [5*FL-1:0] flag_bits;
    logic [2:0]    instr_rm;
    logic [2:0]    rm_resolved;
    logic          rm_illegal;
    logic [2:0]    frm_out;

    rv32f_csr_unit #(.FLAG_LANES(FL), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_op(req_op), .req_wdata(req_wdata), .req_id(req_id),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_illegal(resp_illegal), .resp_id(resp_id),
        .flag_valid(flag_valid), .flag_bits(flag_bits),
        .instr_rm(instr_rm), .rm_resolved(rm_resolved), .rm_illegal(rm_illegal),
        .frm_out(frm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rdata;
        logic          illegal;
        logic [IW-1:0] id;
    } resp_t;

    resp_t       sq[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  m_fflags;
    logic [2:0]  m_frm;
    logic [31:0] m_cnt;
    logic        m_vld;
    logic [IW-1:0] next_id = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fflags = '0;
        m_frm    = '0;
        m_cnt    = '0;
        m_vld    = 1'b0;
        sq.delete();
    endtask

    // Reference model: checks current-state outputs, then advances to the state after the coming edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2:0]  exp_rm;
            logic [4:0]  f;
            longint      n;
            logic        acc;
            logic        ok;
            logic [31:0] oldv;
            logic [31:0] r;
            logic [31:0] w;
            resp_t       e;
            exp_rm = (instr_rm == 3'd7) ? m_frm : instr_rm;
            chk("frm_out", {29'b0, frm_out}, {29'b0, m_frm});
            chk("rm_resolved", {29'b0, rm_resolved}, {29'b0, exp_rm});
            chk("rm_illegal", {31'b0, rm_illegal}, {31'b0, (exp_rm >= 3'd5)});
            chk("req_ready", {31'b0, req_ready}, {31'b0, (!m_vld || resp_ready)});

            f = '0;
            n = 0;
            for (int i = 0; i < FL; i++) begin
                if (flag_valid[i]) begin
                    f = f | flag_bits[5*i +: 5];
                    if (flag_bits[5*i +: 5] != 5'd0) n++;
                end
            end
            m_fflags = m_fflags | f;
            acc = req_valid && (!m_vld || resp_ready);
            ok = 1'b0;
            oldv = '0;
            if (acc) begin
                case (req_addr)
                    12'h001: begin ok = 1'b1; oldv = {27'b0, m_fflags}; end
                    12'h002: begin ok = 1'b1; oldv = {29'b0, m_frm}; end
                    12'h003: begin ok = 1'b1; oldv = {24'b0, m_frm, m_fflags}; end
`ifdef RV32F_CSR_EXC_COUNT_EN
                    12'h800: begin ok = 1'b1; oldv = m_cnt; end
`endif
                    default: ok = 1'b0;
                endcase
                e.rdata = oldv;
                e.illegal = !ok;
                e.id = req_id;
                sq.push_back(e);
            end
            if (m_cnt + n > 64'hFFFF_FFFF) m_cnt = 32'hFFFF_FFFF;
            else m_cnt = m_cnt + 32'(n);
            if (acc && ok && req_op != 2'b00) begin
                w = req_wdata;
                r = (req_op == 2'b01) ? w : (req_op == 2'b10) ? (oldv | w) : (oldv & ~w);
                if (req_addr == 12'h001) m_fflags = r[4:0];
                if (req_addr == 12'h002) m_frm = r[2:0];
                if (req_addr == 12'h003) begin m_fflags = r[4:0]; m_frm = r[7:5]; end
                if (req_addr == 12'h800) m_cnt = r;
            end
            m_vld = acc ? 1'b1 : (resp_ready ? 1'b0 : m_vld);
        end
    end

    // Monitor: every cycle the response is presented it must equal the queue head.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected actual=valid required=no_response");
            end else begin
                chk("resp_rdata", resp_rdata, sq[0].rdata);
                chk("resp_illegal", {31'b0, resp_illegal}, {31'b0, sq[0].illegal});
                chk("resp_id", {28'b0, resp_id}, {28'b0, sq[0].id});
                if (resp_ready) void'(sq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        logic acc;
        int   n;
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        req_wdata = wd;
        req_id    = next_id;
        next_id   = next_id + 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = req_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout actual=not_accepted required=accepted");
        end
        req_valid = 1'b0;
    endtask

    task automatic set_flags(input logic [FL-1:0] v, input logic [5*FL-1:0] b);
        flag_valid = v;
        flag_bits  = b;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_op = '0; req_wdata = '0; req_id = '0;
        resp_ready = 1'b1; flag_valid = '0; flag_bits = '0; instr_rm = 3'd0;
        model_reset();
        #12;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_illegal", {31'b0, resp_illegal}, 32'd0);
        chk("rst_resp_id", {28'b0, resp_id}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_frm", {29'b0, frm_out}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        do_req(12'h003, 2'b00, 32'h0);
        do_req(12'h003, 2'b01, 32'hFFFF_FFE5);
        tick();
        chk("fcsr_wr_frm", {29'b0, frm_out}, 32'd7);
        instr_rm = 3'd7;
        #1;
        chk("dyn_rm_resolved", {29'b0, rm_resolved}, 32'd7);
        chk("dyn_rm_illegal", {31'b0, rm_illegal}, 32'd1);
        instr_rm = 3'd1;
        #1;
        chk("static_rm_resolved", {29'b0, rm_resolved}, 32'd1);
        chk("static_rm_illegal", {31'b0, rm_illegal}, 32'd0);
        do_req(12'h003, 2'b00, 32'h0);

        set_flags(2'b11, {5'h08, 5'h01});
        tick();
        set_flags(2'b00, '0);
        do_req(12'h001, 2'b00, 32'h0);
        do_req(12'h001, 2'b11, 32'h08);
        do_req(12'h001, 2'b00, 32'h0);

        do_req(12'h001, 2'b01, 32'h0);
        set_flags(2'b01, {5'h00, 5'h10});
        do_req(12'h001, 2'b10, 32'h02);
        set_flags(2'b00, '0);
        do_req(12'h001, 2'b00, 32'h0);

        resp_ready = 1'b0;
        fork
            begin
                do_req(12'h002, 2'b00, 32'h0);
                do_req(12'h7C0, 2'b01, 32'hFFFF_FFFF);
            end
            begin
                repeat (4) tick();
                resp_ready = 1'b1;
            end
        join
        tick();

        do_req(12'h800, 2'b01, 32'h0);
        set_flags(2'b11, {5'h04, 5'h02});
        repeat (4) tick();
        set_flags(2'b00, '0);
        do_req(12'h800, 2'b00, 32'h0);
        tick();

        resp_ready = 1'b0;
        do_req(12'h001, 2'b00, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
        model_reset();
        resp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 5))
                0: req_addr = 12'h001;
                1: req_addr = 12'h002;
                2: req_addr = 12'h003;
                3: req_addr = 12'h800;
                4: req_addr = 12'h7C0;
                default: req_addr = 12'($urandom);
            endcase
            req_valid  = ($urandom_range(0, 2) != 0);
            req_op     = 2'($urandom);
            req_wdata  = $urandom;
            req_id     = IW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            flag_valid = FL'($urandom);
            flag_bits  = (5*FL)'($urandom);
            instr_rm   = 3'($urandom);
            tick();
        end

        req_valid = 1'b0;
        resp_ready = 1'b1;
        set_flags(2'b00, '0);
        repeat (5) tick();
        chk("queue_drained", sq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
